alu_issue_ctrl: RTL and testbench
=================================

# alu_issue_ctrl

Sequential request/response front end for the 16-bit combinational ALU. Accepts one operation per handshake from the decode stage and registers the operands onto the ALU's A/B/op inputs. It captures the ALU's out/comp one cycle later and returns them on a response channel with backpressure. It also keeps a last-compare flag register for branch logic and a sticky error flag for malformed comparator codes.

## Interface
Parameters:
- DW, 16, data width of A, B and out
- OW, 4, opcode width

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when high with req_valid
- req_op  in  OW  ALU opcode
- req_a  in  DW  operand A (two's complement)
- req_b  in  DW  operand B (two's complement)
- alu_a  out  DW  to ALU A
- alu_b  out  DW  to ALU B
- alu_op  out  OW  to ALU op
- alu_out  in  DW  from ALU out
- alu_comp  in  3  from ALU comp: 100 A>B, 010 A==B, 001 A<B (signed)
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when high with rsp_valid
- rsp_data  out  DW  captured alu_out
- rsp_comp  out  3  captured alu_comp
- flags  out  3  alu_comp of the most recent OP_SUB
- comp_err  out  1  sticky, set when a captured alu_comp is not one-hot
- err_clr  in  1  synchronous clear of comp_err

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE: req_ready=1. On req_valid, latch req_op/a/b into the alu_* registers and go to EXEC.
- EXEC: req_ready=0 and rsp_valid=0. The ALU settles for one full cycle. At the end of the cycle:
  - alu_out goes to rsp_data and alu_comp goes to rsp_comp.
  - If alu_op==OP_SUB, flags is loaded with alu_comp.
  - If alu_comp is not one-hot, comp_err is set.
  - Go to RESP.
- RESP: rsp_valid=1. rsp_data and rsp_comp are stable until the handshake.
  - rsp_ready=0: stay in RESP.
  - rsp_ready=1 and req_valid=0: go to IDLE.
  - rsp_ready=1 and req_valid=1: accept the new request in the same edge and go to EXEC.
- req_ready = (state==IDLE) | (state==RESP & rsp_ready). This combinational path from rsp_ready is intentional; upstream must not make req_valid depend on req_ready.
- alu_* registers change only on request acceptance. They hold their values in IDLE and RESP.
- flags is unchanged by non-SUB ops.
- comp_err: err_clr has priority over a set in the same cycle.
- Arithmetic: none inside the block. Data passes through bit-exact with no width change.

## Timing
- Reset (rst_n low, asynchronous):
  - state=IDLE
  - alu_a, alu_b, alu_op, rsp_data = 0
  - rsp_comp = 0, flags = 0
  - rsp_valid = 0, comp_err = 0
  - req_ready = 0 while rst_n is low, 1 in the first cycle after release.
- Latency: request accepted at edge k. alu_* are valid after edge k. The result is captured at edge k+1. rsp_valid=1 after edge k+1.
- Peak throughput is one op per 2 cycles, achieved with back-to-back accept in RESP.
- Reset mid-EXEC or mid-RESP: the in-flight operation is dropped, no response is issued, and flags/comp_err are cleared.
- Backpressure of any length in RESP is lossless. No second request is accepted until the response handshakes.

## Structure
- Shared package alu_pkg holds:
  - OP_SUB=4'b0001
  - COMP_GT=3'b100, COMP_EQ=3'b010, COMP_LT=3'b001
  - the FSM state enum
- Single module, no sub-module. The ALU is instantiated by the parent and connected through the alu_* ports.

## Test plan
- op=0001, A=5, B=2 → after 2 cycles rsp_valid=1, rsp_data=3, rsp_comp=100, flags=100.
- Signed compare sequence: A=-6 (16'hFFFA), B=4 → rsp_comp=001. Then A=B=-6 → rsp_comp=010, rsp_data=0. flags tracks each result.
- Non-SUB op (4'b0110) after a SUB that set flags=001 → flags stays 001. rsp_data equals the ALU model output.
- Backpressure: hold rsp_ready=0 for 5 cycles with req_valid=1 → req_ready stays 0 and rsp_data is stable. Then rsp_ready=1 → the new request is accepted in the same edge and the next rsp_valid arrives 2 cycles later.
- Forced alu_comp=110 from the ALU model → comp_err=1 and stays 1 across later good ops. err_clr pulse → 0. err_clr together with another bad comp → 0.
- Assert rst_n=0 during EXEC → all outputs are 0 immediately and no rsp_valid follows. After release the first request completes normally with 2-cycle latency.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: opcode and comparator codes, FSM states.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package alu_pkg;

  localparam logic [3:0] OP_SUB  = 4'b0001;

  localparam logic [2:0] COMP_GT = 3'b100;
  localparam logic [2:0] COMP_EQ = 3'b010;
  localparam logic [2:0] COMP_LT = 3'b001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  // A well-formed comparator result is exactly one of the three legal codes.
  function automatic logic comp_is_onehot(input logic [2:0] comp);
    return (comp == COMP_GT) || (comp == COMP_EQ) || (comp == COMP_LT);
  endfunction

endpackage

// File: rtl/alu_issue_ctrl.sv
// Request/response front end for the combinational ALU: registers operands onto the ALU, captures its result.
// Latency: accept at edge k, result captured at edge k+1, rsp_valid high after k+1 (one op per 2 cycles peak).
// Backpressure: response held stable in RESP until rsp_ready; a new request is accepted on the handshake edge.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   req_valid/req_ready         request handshake; req_op, req_a, req_b carry the operation
//   alu_a, alu_b, alu_op        registered operands to the external ALU
//   alu_out, alu_comp           ALU result and signed compare code (100 GT, 010 EQ, 001 LT)
//   rsp_valid/rsp_ready         response handshake; rsp_data, rsp_comp carry the captured result
//   flags                       compare code of the most recent subtract
//   comp_err, err_clr           sticky malformed-compare flag and its synchronous clear
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int DW = 16,
  parameter int OW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [OW-1:0] req_op,
  input  logic [DW-1:0] req_a,
  input  logic [DW-1:0] req_b,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [OW-1:0] alu_op,
  input  logic [DW-1:0] alu_out,
  input  logic [2:0]    alu_comp,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic [2:0]    rsp_comp,
  output logic [2:0]    flags,
  output logic          comp_err,
  input  logic          err_clr
);

  state_e        state_q, state_d;
  logic [DW-1:0] alu_a_q, alu_b_q;
  logic [OW-1:0] alu_op_q;
  logic [DW-1:0] rsp_data_q;
  logic [2:0]    rsp_comp_q;
  logic [2:0]    flags_q, flags_d;
  logic          comp_err_q, comp_err_d;
  logic          req_ready_c;
  logic          accept;
  logic          capture;

  // req_ready includes rst_n so it reads low for the whole time reset is asserted.
  always_comb begin
    req_ready_c = 1'b0;
    if (rst_n) begin
      req_ready_c = (state_q == IDLE) || ((state_q == RESP) && rsp_ready);
    end
  end

  assign accept  = req_valid && req_ready_c;
  assign capture = (state_q == EXEC);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_valid) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = req_valid ? EXEC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    flags_d = flags_q;
    if (capture && (alu_op_q == OW'(OP_SUB))) begin
      flags_d = alu_comp;
    end
  end

  // Clear wins over a set landing in the same cycle.
  always_comb begin
    comp_err_d = comp_err_q;
    if (err_clr) begin
      comp_err_d = 1'b0;
    end else if (capture && !comp_is_onehot(alu_comp)) begin
      comp_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      rsp_data_q <= '0;
      rsp_comp_q <= '0;
      flags_q    <= '0;
      comp_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      flags_q    <= flags_d;
      comp_err_q <= comp_err_d;
      if (accept) begin
        alu_a_q  <= req_a;
        alu_b_q  <= req_b;
        alu_op_q <= req_op;
      end
      if (capture) begin
        rsp_data_q <= alu_out;
        rsp_comp_q <= alu_comp;
      end
    end
  end

  assign req_ready = req_ready_c;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign rsp_valid = (state_q == RESP);
  assign rsp_data  = rsp_data_q;
  assign rsp_comp  = rsp_comp_q;
  assign flags     = flags_q;
  assign comp_err  = comp_err_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl with an in-bench ALU and a transaction-level reference model.
// Latency: checks accept-to-response of exactly two edges.
// Backpressure: random response stalls with a pending request; response must stay stable.
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [3:0]  req_op;
  logic [15:0] req_a, req_b;
  logic [15:0] alu_a, alu_b;
  logic [3:0]  alu_op;
  logic [15:0] alu_out;
  logic [2:0]  alu_comp;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_data;
  logic [2:0]  rsp_comp;
  logic [2:0]  flags;
  logic        comp_err, err_clr;
  logic        bad_comp;

  int checks = 0;
  int errors = 0;

  // Reference state: what the bench expects the architectural flags to hold.
  logic [2:0] flags_exp;
  logic       err_exp;
  bit         in_resp;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.DW(16), .OW(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_out(alu_out), .alu_comp(alu_comp),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_comp(rsp_comp),
    .flags(flags), .comp_err(comp_err), .err_clr(err_clr)
  );

  function automatic logic [15:0] alu_fn(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd4:    return a ^ b;
      4'd5:    return ~a;
      4'd6:    return a & ~b;
      default: return b;
    endcase
  endfunction

  function automatic logic [2:0] cmp_fn(input logic [15:0] a, input logic [15:0] b);
    if ($signed(a) > $signed(b)) return 3'b100;
    if (a == b)                  return 3'b010;
    return 3'b001;
  endfunction

  // Combinational ALU driven by the DUT's registered operands; bad_comp forces an illegal code.
  always_comb begin
    alu_out  = alu_fn(alu_op, alu_a, alu_b);
    alu_comp = bad_comp ? 3'b110 : cmp_fn(alu_a, alu_b);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one op (accepting on the handshake edge if a response is pending), check it, then stall.
  task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input bit bad, input int stall, input bit clr);
    logic [15:0] exp_out;
    logic [2:0]  exp_comp;
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    bad_comp  = bad;
    rsp_ready = in_resp;
    #1 chk("req_ready_accept", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    chk("alu_a", 32'(alu_a), 32'(a));
    chk("alu_b", 32'(alu_b), 32'(b));
    chk("alu_op", 32'(alu_op), 32'(op));
    chk("exec_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("exec_req_ready", 32'(req_ready), 32'd0);
    req_valid = 1'b0; rsp_ready = 1'b0; err_clr = clr;
    exp_out  = alu_fn(op, a, b);
    exp_comp = bad ? 3'b110 : cmp_fn(a, b);
    if (op == 4'b0001) flags_exp = exp_comp;
    if (clr)      err_exp = 1'b0;
    else if (bad) err_exp = 1'b1;
    @(posedge clk); #1;
    err_clr = 1'b0; bad_comp = 1'b0;
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_data", 32'(rsp_data), 32'(exp_out));
    chk("rsp_comp", 32'(rsp_comp), 32'(exp_comp));
    chk("flags", 32'(flags), 32'(flags_exp));
    chk("comp_err", 32'(comp_err), 32'(err_exp));
    for (int i = 0; i < stall; i++) begin
      req_valid = 1'b1; req_a = 16'($urandom); req_b = 16'($urandom);
      req_op = 4'($urandom_range(0, 7));
      #1 chk("stall_req_ready", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
      chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("stall_rsp_data", 32'(rsp_data), 32'(exp_out));
      chk("stall_alu_a", 32'(alu_a), 32'(a));
    end
    req_valid = 1'b0;
    in_resp = 1'b1;
  endtask

  task automatic drain();
    req_valid = 1'b0;
    if (in_resp) begin
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      chk("drain_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("drain_req_ready", 32'(req_ready), 32'd1);
      in_resp = 1'b0;
    end
  endtask

  task automatic clr_pulse();
    err_clr = 1'b1; rsp_ready = 1'b0; req_valid = 1'b0;
    @(posedge clk); #1;
    err_clr = 1'b0; err_exp = 1'b0;
    chk("clr_comp_err", 32'(comp_err), 32'd0);
    chk("clr_rsp_valid", 32'(rsp_valid), 32'(in_resp));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_alu_a"},    32'(alu_a), 32'd0);
    chk({tag, "_alu_b"},    32'(alu_b), 32'd0);
    chk({tag, "_alu_op"},   32'(alu_op), 32'd0);
    chk({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
    chk({tag, "_rsp_comp"}, 32'(rsp_comp), 32'd0);
    chk({tag, "_flags"},    32'(flags), 32'd0);
    chk({tag, "_rsp_vld"},  32'(rsp_valid), 32'd0);
    chk({tag, "_comp_err"}, 32'(comp_err), 32'd0);
    chk({tag, "_req_rdy"},  32'(req_ready), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0;
    rsp_ready = 1'b0; err_clr = 1'b0; bad_comp = 1'b0;
    flags_exp = '0; err_exp = 1'b0; in_resp = 1'b0;
    #2 check_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 chk("post_reset_req_ready", 32'(req_ready), 32'd1);
    chk("post_reset_rsp_valid", 32'(rsp_valid), 32'd0);

    // Directed: basic subtract and signed compares.
    run_op(4'b0001, 16'd5, 16'd2, 0, 0, 0);
    run_op(4'b0001, 16'hFFFA, 16'd4, 0, 0, 0);
    run_op(4'b0001, 16'hFFFA, 16'hFFFA, 0, 0, 0);
    run_op(4'b0001, 16'hFFFA, 16'd4, 0, 0, 0);
    // Non-subtract leaves flags alone.
    run_op(4'b0110, 16'h1234, 16'h00F0, 0, 0, 0);
    // Backpressure with a pending request, then same-edge accept.
    run_op(4'b0000, 16'h7FFF, 16'h0001, 0, 5, 0);
    run_op(4'b0001, 16'h8000, 16'h0001, 0, 0, 0);
    // Malformed compare: sticky, clearable, clear beats set.
    run_op(4'b0010, 16'h00FF, 16'h0F0F, 1, 0, 0);
    run_op(4'b0011, 16'h0001, 16'h0002, 0, 1, 0);
    clr_pulse();
    run_op(4'b0001, 16'd9, 16'd3, 1, 0, 1);
    drain();

    // Reset while an op is executing: dropped, everything cleared.
    req_valid = 1'b1; req_op = 4'b0001; req_a = 16'd10; req_b = 16'd20;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1 check_zero("midexec");
    @(posedge clk); #1;
    rst_n = 1'b1;
    flags_exp = '0; err_exp = 1'b0; in_resp = 1'b0;
    #1 chk("midexec_req_ready", 32'(req_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("midexec_no_rsp", 32'(rsp_valid), 32'd0);
    end
    run_op(4'b0001, 16'd100, 16'd1, 0, 0, 0);

    // Randomized traffic.
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 4) == 0) drain();
      if (in_resp && $urandom_range(0, 9) == 0) clr_pulse();
      run_op(4'($urandom_range(0, 7)), 16'($urandom), 16'($urandom),
             ($urandom_range(0, 7) == 0), $urandom_range(0, 3), ($urandom_range(0, 5) == 0));
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
